// File: rtl/vga_timing_if.sv
// Pixel-timing bundle presented by the timing generator to the colour stage.
interface vga_timing_if;
    logic       pix_en_o;
    logic [9:0] xcol_o;
    logic [9:0] yrow_o;
    logic       disp_active;
    logic       hsync_o;
    logic       vsync_o;
    logic       line_start_o;
    logic       frame_start_o;

    modport master (
        output pix_en_o, xcol_o, yrow_o, disp_active,
               hsync_o, vsync_o, line_start_o, frame_start_o
    );

    modport slave (
        input  pix_en_o, xcol_o, yrow_o, disp_active,
               hsync_o, vsync_o, line_start_o, frame_start_o
    );
endinterface

// File: rtl/vga_timing_gen.sv
// VGA pixel timing: clock-enable divider plus horizontal/vertical position
// counters, with sync, active-video and line/frame markers decoded from them.
// Every output is a decode of registered state, so nothing here is
// combinationally reachable from an input.
module vga_timing_gen #(
    parameter int CLK_DIV   = 4,
    parameter int H_ACTIVE  = 640,
    parameter int H_FP      = 16,
    parameter int H_SYNC    = 96,
    parameter int H_BP      = 48,
    parameter int V_ACTIVE  = 480,
    parameter int V_FP      = 10,
    parameter int V_SYNC    = 2,
    parameter int V_BP      = 33,
    parameter bit HSYNC_POL = 1'b0,
    parameter bit VSYNC_POL = 1'b0
) (
    input  logic         clk_i,
    input  logic         rst_i,
    vga_timing_if.master vga
);

    localparam int H_TOTAL = H_ACTIVE + H_FP + H_SYNC + H_BP;
    localparam int V_TOTAL = V_ACTIVE + V_FP + V_SYNC + V_BP;

    if (H_TOTAL > 1024 || V_TOTAL > 1024) begin : g_bad_total
        $error("vga_timing_gen: H_TOTAL/V_TOTAL must not exceed 1024");
    end
    if (CLK_DIV < 1 || CLK_DIV > 16) begin : g_bad_div
        $error("vga_timing_gen: CLK_DIV must be within 1..16");
    end

    localparam logic [3:0]  DIV_LAST = 4'(CLK_DIV - 1);
    localparam logic [9:0]  H_LAST   = 10'(H_TOTAL - 1);
    localparam logic [9:0]  V_LAST   = 10'(V_TOTAL - 1);
    // Decode bounds are one bit wider so an end bound of 1024 does not wrap.
    localparam logic [10:0] H_ACT_END = 11'(H_ACTIVE);
    localparam logic [10:0] V_ACT_END = 11'(V_ACTIVE);
    localparam logic [10:0] HS_START  = 11'(H_ACTIVE + H_FP);
    localparam logic [10:0] HS_END    = 11'(H_ACTIVE + H_FP + H_SYNC);
    localparam logic [10:0] VS_START  = 11'(V_ACTIVE + V_FP);
    localparam logic [10:0] VS_END    = 11'(V_ACTIVE + V_FP + V_SYNC);

    logic [3:0] div_q, div_d;
    logic [9:0] hcnt_q, hcnt_d;
    logic [9:0] vcnt_q, vcnt_d;
    logic       pix_en;
    logic       h_in_sync;
    logic       v_in_sync;

    // Pixel strobe marks the last system cycle of each pixel period.
    assign pix_en = (div_q == DIV_LAST);

    // Next-state: divider wraps on the strobe; counters step only on the strobe.
    always_comb begin
        div_d  = pix_en ? 4'd0 : div_q + 4'd1;
        hcnt_d = hcnt_q;
        vcnt_d = vcnt_q;
        if (pix_en) begin
            if (hcnt_q == H_LAST) begin
                hcnt_d = 10'd0;
                vcnt_d = (vcnt_q == V_LAST) ? 10'd0 : vcnt_q + 10'd1;
            end else begin
                hcnt_d = hcnt_q + 10'd1;
            end
        end
    end

    // State registers, cleared asynchronously so outputs reset without a clock.
    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            div_q  <= 4'd0;
            hcnt_q <= 10'd0;
            vcnt_q <= 10'd0;
        end else begin
            div_q  <= div_d;
            hcnt_q <= hcnt_d;
            vcnt_q <= vcnt_d;
        end
    end

    // Output decodes from registered counters only.
    always_comb begin
        h_in_sync = ({1'b0, hcnt_q} >= HS_START) && ({1'b0, hcnt_q} < HS_END);
        v_in_sync = ({1'b0, vcnt_q} >= VS_START) && ({1'b0, vcnt_q} < VS_END);

        vga.pix_en_o      = pix_en;
        vga.xcol_o        = hcnt_q;
        vga.yrow_o        = vcnt_q;
        vga.disp_active   = ({1'b0, hcnt_q} < H_ACT_END) && ({1'b0, vcnt_q} < V_ACT_END);
        vga.hsync_o       = h_in_sync ? HSYNC_POL : ~HSYNC_POL;
        vga.vsync_o       = v_in_sync ? VSYNC_POL : ~VSYNC_POL;
        vga.line_start_o  = pix_en && (hcnt_q == 10'd0);
        vga.frame_start_o = pix_en && (hcnt_q == 10'd0) && (vcnt_q == 10'd0);
    end

endmodule

// File: tb/tb_vga_timing_gen.sv
// Bench for vga_timing_gen: default build (measured timing), a small-geometry
// build with a per-pixel scoreboard and a mid-frame reset, and a CLK_DIV=1 build.
module tb_vga_timing_gen;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic rst_d4 = 1'b1;
    logic rst_sm = 1'b1;
    logic rst_d1 = 1'b1;

    vga_timing_if if_d4 ();
    vga_timing_if if_sm ();
    vga_timing_if if_d1 ();

    vga_timing_gen u_d4 (.clk_i(clk), .rst_i(rst_d4), .vga(if_d4));

    // Small frame: H_TOTAL=15 (sync at x=10..12), V_TOTAL=10 (sync at y=7..8).
    vga_timing_gen #(
        .CLK_DIV(3), .H_ACTIVE(8), .H_FP(2), .H_SYNC(3), .H_BP(2),
        .V_ACTIVE(6), .V_FP(1), .V_SYNC(2), .V_BP(1),
        .HSYNC_POL(1'b1), .VSYNC_POL(1'b0)
    ) u_sm (.clk_i(clk), .rst_i(rst_sm), .vga(if_sm));

    vga_timing_gen #(.CLK_DIV(1)) u_d1 (.clk_i(clk), .rst_i(rst_d1), .vga(if_d1));

    int errors = 0;
    int checks = 0;

    task automatic chk(input string name, input int act, input int exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0d, expected %0d", name, act, exp);
        end
    endtask

    typedef struct packed {
        int x; int y;
        bit hs; bit vs; bit act; bit ls; bit fs;
    } pix_t;

    pix_t sb_q[$];

    // Expected values for the small geometry, worked out by hand.
    task automatic push_sm(input int x, input int y);
        pix_t e;
        e.x   = x;
        e.y   = y;
        e.hs  = (x >= 10 && x <= 12);        // active-high hsync
        e.vs  = !(y == 7 || y == 8);         // active-low vsync
        e.act = (x < 8 && y < 6);
        e.ls  = (x == 0);
        e.fs  = (x == 0 && y == 0);
        sb_q.push_back(e);
    endtask

    // Scoreboard monitor for the small build: compare on every pixel strobe,
    // and check the strobe spacing (including first strobe after reset).
    int sm_since = 0;
    always @(negedge clk) begin
        pix_t e;
        pix_t a;
        if (rst_sm) begin
            sm_since = 0;
        end else begin
            sm_since++;
            if (if_sm.pix_en_o) begin
                chk("sm_pix_en_spacing", sm_since, 3);
                sm_since = 0;
                if (sb_q.size() > 0) begin
                    e = sb_q.pop_front();
                    a.x   = int'(if_sm.xcol_o);
                    a.y   = int'(if_sm.yrow_o);
                    a.hs  = if_sm.hsync_o;
                    a.vs  = if_sm.vsync_o;
                    a.act = if_sm.disp_active;
                    a.ls  = if_sm.line_start_o;
                    a.fs  = if_sm.frame_start_o;
                    checks++;
                    if (a !== e) begin
                        errors++;
                        $display("FAIL sm_pixel: got (%0d,%0d) hs=%0b vs=%0b act=%0b ls=%0b fs=%0b, expected (%0d,%0d) hs=%0b vs=%0b act=%0b ls=%0b fs=%0b",
                                 a.x, a.y, a.hs, a.vs, a.act, a.ls, a.fs,
                                 e.x, e.y, e.hs, e.vs, e.act, e.ls, e.fs);
                    end
                end
            end
        end
    end

    initial begin
        // Frame 0 in full, then frame 1 up to pixel (5,4).
        for (int y = 0; y < 10; y++)
            for (int x = 0; x < 15; x++) push_sm(x, y);
        for (int y = 0; y < 4; y++)
            for (int x = 0; x < 15; x++) push_sm(x, y);
        for (int x = 0; x <= 5; x++) push_sm(x, 4);

        // Reset values while reset is held (reset applied by the first edge).
        @(posedge clk);
        #2;
        chk("d4_rst_xcol",   if_d4.xcol_o, 0);
        chk("d4_rst_yrow",   if_d4.yrow_o, 0);
        chk("d4_rst_active", if_d4.disp_active, 1);
        chk("d4_rst_hsync",  if_d4.hsync_o, 1);
        chk("d4_rst_vsync",  if_d4.vsync_o, 1);
        chk("d4_rst_pix_en", if_d4.pix_en_o, 0);
        chk("d4_rst_ls",     if_d4.line_start_o, 0);
        chk("d4_rst_fs",     if_d4.frame_start_o, 0);
        chk("sm_rst_hsync",  if_sm.hsync_o, 0);
        chk("d1_rst_pix_en", if_d1.pix_en_o, 1);
        chk("d1_rst_fs",     if_d1.frame_start_o, 1);
        rst_d4 = 1'b0;
        rst_sm = 1'b0;
        rst_d1 = 1'b0;

        fork
            // Default build: timing measured over three lines.
            begin
                int n;
                int cyc;
                int ls_cnt;
                int ls_prev;
                int hs_low;
                int hs_first_x;
                int vs_low;
                int act_drop_x;
                int wrap_y;
                bit wrap_armed;
                int pe_cnt;
                int pe_prev;
                n = 0;
                do begin
                    @(negedge clk);
                    n++;
                end while (!if_d4.pix_en_o && n < 20);
                chk("d4_first_pix_en_latency", n, 4);
                chk("d4_first_fs", if_d4.frame_start_o, 1);
                cyc = 0; ls_cnt = 0; ls_prev = 0; hs_low = 0; hs_first_x = -1;
                vs_low = 0; act_drop_x = -1; wrap_armed = 0; wrap_y = 0;
                pe_cnt = 0; pe_prev = 0;
                while (cyc < 9700) begin
                    if (if_d4.line_start_o) begin
                        if (ls_cnt > 0 && ls_cnt < 3)
                            chk("d4_line_period", cyc - ls_prev, 3200);
                        ls_prev = cyc;
                        ls_cnt++;
                    end
                    if (if_d4.pix_en_o) begin
                        if (pe_cnt > 0 && pe_cnt < 3)
                            chk("d4_pix_en_period", cyc - pe_prev, 4);
                        pe_prev = cyc;
                        pe_cnt++;
                        if (wrap_armed) begin
                            chk("d4_wrap_xcol", if_d4.xcol_o, 0);
                            chk("d4_wrap_yrow", if_d4.yrow_o, wrap_y + 1);
                            wrap_armed = 0;
                            wrap_y = -100;
                        end else if (if_d4.xcol_o == 10'd799 && wrap_y == 0) begin
                            wrap_y = int'(if_d4.yrow_o);
                            wrap_armed = 1;
                        end
                    end
                    if (cyc < 3200 && !if_d4.hsync_o) begin
                        if (hs_first_x < 0) hs_first_x = int'(if_d4.xcol_o);
                        hs_low++;
                    end
                    if (!if_d4.vsync_o) vs_low++;
                    if (act_drop_x < 0 && !if_d4.disp_active) act_drop_x = int'(if_d4.xcol_o);
                    @(negedge clk);
                    cyc++;
                end
                chk("d4_line_starts_in_3_lines", ls_cnt, 4);
                chk("d4_hsync_first_x", hs_first_x, 656);
                chk("d4_hsync_low_cycles", hs_low, 384);
                chk("d4_vsync_low_early_lines", vs_low, 0);
                chk("d4_active_drop_x", act_drop_x, 640);
                chk("d4_wrap_seen", wrap_y, -100);
            end
            // Small build: scoreboard drain, mid-frame reset, restart from (0,0).
            begin
                for (int i = 0; i < 3000 && sb_q.size() > 0; i++) @(posedge clk);
                chk("sm_drain_frame", sb_q.size(), 0);
                #1;
                chk("sm_pre_reset_xcol", if_sm.xcol_o, 6);
                chk("sm_pre_reset_yrow", if_sm.yrow_o, 4);
                #1;
                rst_sm = 1'b1;
                #1;
                chk("sm_midrst_xcol",   if_sm.xcol_o, 0);
                chk("sm_midrst_yrow",   if_sm.yrow_o, 0);
                chk("sm_midrst_active", if_sm.disp_active, 1);
                chk("sm_midrst_hsync",  if_sm.hsync_o, 0);
                chk("sm_midrst_vsync",  if_sm.vsync_o, 1);
                chk("sm_midrst_pix_en", if_sm.pix_en_o, 0);
                chk("sm_midrst_fs",     if_sm.frame_start_o, 0);
                repeat (3) @(posedge clk);
                #2;
                for (int y = 0; y < 2; y++)
                    for (int x = 0; x < 15; x++) push_sm(x, y);
                rst_sm = 1'b0;
                for (int i = 0; i < 500 && sb_q.size() > 0; i++) @(posedge clk);
                chk("sm_drain_after_reset", sb_q.size(), 0);
            end
            // CLK_DIV=1 build: strobe constantly high, 800-cycle lines.
            begin
                int pe_low;
                int ls_cnt;
                int ls_prev;
                pe_low = 0; ls_cnt = 0; ls_prev = 0;
                for (int cyc = 0; cyc < 1700; cyc++) begin
                    @(negedge clk);
                    if (!if_d1.pix_en_o) pe_low++;
                    if (if_d1.line_start_o) begin
                        if (ls_cnt > 0) begin
                            chk("d1_line_period", cyc - ls_prev, 800);
                            chk("d1_line_yrow", if_d1.yrow_o, ls_cnt);
                        end
                        ls_prev = cyc;
                        ls_cnt++;
                    end
                end
                chk("d1_pix_en_low_cycles", pe_low, 0);
                chk("d1_line_starts", ls_cnt, 3);
            end
        join

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
